branch_predictor: RTL and testbench

- Fetch-side partner of the branch control unit: predicts branch/jump direction and target at IF from the fetch PC.
- Consumes the resolved outcome from the EX-stage branch control unit, trains a direct-mapped branch target buffer (BTB) of 2-bit saturating counters, and raises a registered mispredict/redirect to the PC/flush logic.

---
 rtl/branch_predictor_pkg.sv | 27 ++
 rtl/branch_predictor_sat_counter2.sv | 32 +++
 rtl/branch_predictor.sv | 143 ++++++++++++++
 tb/tb_branch_predictor.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// -----------------------------------------------------------------------------
// branch_predictor_pkg
// Purpose : Shared encodings for the fetch-side branch predictor and the
//           EX-stage branch control unit.
//           - branch_op_e : BranchOp field carried with every instruction
//           - cnt_state_e : states of the 2-bit saturating direction counter
// Ports   : none (package)
// -----------------------------------------------------------------------------
package branch_predictor_pkg;

    // BranchOp encodings, shared with the branch control unit
    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_EQ   = 2'd1,
        BR_NE   = 2'd2,
        BR_JUMP = 2'd3
    } branch_op_e;

    // 2-bit direction counter states; bit 1 set means "predict taken"
    typedef enum logic [1:0] {
        CNT_SNT = 2'd0,
        CNT_WNT = 2'd1,
        CNT_WT  = 2'd2,
        CNT_ST  = 2'd3
    } cnt_state_e;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// -----------------------------------------------------------------------------
// sat_counter2
// Purpose : Next-state function of a 2-bit saturating up/down counter.
//           Purely combinational; the caller owns the state register.
// Ports   :
//   cnt      in  2  current counter value
//   up       in  1  1 = count up (branch taken), 0 = count down
//   next_cnt out 2  updated value, saturating at CNT_ST / CNT_SNT
// -----------------------------------------------------------------------------
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       up,
    output logic [1:0] next_cnt
);

    // Step one position toward the observed direction, sticking at the ends
    always_comb begin
        next_cnt = cnt;
        if (up) begin
            if (cnt != CNT_ST) begin
                next_cnt = cnt + 2'd1;
            end
        end else begin
            if (cnt != CNT_SNT) begin
                next_cnt = cnt - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
// Purpose : Direct-mapped BTB with 2-bit saturating direction counters.
//           Predicts direction/target combinationally from the fetch PC,
//           trains on the resolved outcome from EX, and raises a registered
//           one-cycle mispredict pulse with the corrected next PC.
// Ports   :
//   clk, rst                 clock (rising edge), async active-high reset
//   f_pc                     PC being fetched
//   pred_taken, pred_target  combinational prediction for f_pc
//   r_valid, r_pc            resolved instruction present in EX and its PC
//   r_branchop               BranchOp of the resolved instruction
//   r_taken, r_target        actual outcome from the branch control unit
//   r_pred_taken/_target     prediction that travelled with the instruction
//   mispredict, redirect_pc  registered flush request and correct next PC
//   branch_cnt, miss_cnt     wrapping performance counters
// -----------------------------------------------------------------------------
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_BITS = 4,
    parameter int ADDR_W   = 32,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] f_pc,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              r_valid,
    input  logic [ADDR_W-1:0] r_pc,
    input  logic [1:0]        r_branchop,
    input  logic              r_taken,
    input  logic [ADDR_W-1:0] r_target,
    input  logic              r_pred_taken,
    input  logic [ADDR_W-1:0] r_pred_target,
    output logic              mispredict,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = ADDR_W - IDX_BITS - 2;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [1:0]        cnt_q    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];

    logic [IDX_BITS-1:0] f_idx;
    logic [TAG_W-1:0]    f_tag;
    logic                f_hit;

    logic [IDX_BITS-1:0] r_idx;
    logic [TAG_W-1:0]    r_tag;
    logic                r_hit;
    logic                is_branch;
    logic                resolve_ev;
    logic                miss_cond;
    logic [1:0]          cnt_next;

    // Fetch-side lookup; reads the table as it stands before any same-cycle write
    always_comb begin
        f_idx       = f_pc[IDX_BITS+1:2];
        f_tag       = f_pc[ADDR_W-1:IDX_BITS+2];
        f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        pred_taken  = f_hit && cnt_q[f_idx][1];
        pred_target = f_hit ? target_q[f_idx] : f_pc + ADDR_W'(4);
    end

    // Resolve-side decode. The instruction in EX during a mispredict pulse is
    // on the wrong path, so it is ignored entirely. A non-branch that was
    // predicted taken means the BTB entry aliased or went stale.
    always_comb begin
        r_idx      = r_pc[IDX_BITS+1:2];
        r_tag      = r_pc[ADDR_W-1:IDX_BITS+2];
        r_hit      = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
        is_branch  = (r_branchop != BR_NONE);
        resolve_ev = r_valid && !mispredict;
        if (is_branch) begin
            miss_cond = (r_taken != r_pred_taken) ||
                        (r_taken && (r_target != r_pred_target));
        end else begin
            miss_cond = r_pred_taken;
        end
    end

    sat_counter2 u_sat_counter2 (
        .cnt      (cnt_q[r_idx]),
        .up       (r_taken),
        .next_cnt (cnt_next)
    );

    // Flush request, corrected PC and performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispredict  <= 1'b0;
            redirect_pc <= '0;
            branch_cnt  <= '0;
            miss_cnt    <= '0;
        end else begin
            mispredict <= resolve_ev && miss_cond;
            if (resolve_ev && miss_cond) begin
                redirect_pc <= r_taken ? r_target : r_pc + ADDR_W'(4);
                miss_cnt    <= miss_cnt + CNT_W'(1);
            end
            if (resolve_ev && is_branch) begin
                branch_cnt <= branch_cnt + CNT_W'(1);
            end
        end
    end

    // BTB training. A not-taken miss is not worth allocating; a taken miss
    // allocates with a jump starting strongly taken and a branch weakly taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                cnt_q[i]    <= CNT_WNT;
                target_q[i] <= '0;
            end
        end else if (resolve_ev) begin
            if (is_branch) begin
                if (r_hit) begin
                    cnt_q[r_idx] <= cnt_next;
                    if (r_taken) begin
                        target_q[r_idx] <= r_target;
                    end
                end else if (r_taken) begin
                    valid_q[r_idx]  <= 1'b1;
                    tag_q[r_idx]    <= r_tag;
                    target_q[r_idx] <= r_target;
                    cnt_q[r_idx]    <= (r_branchop == BR_JUMP) ? CNT_ST : CNT_WT;
                end
            end else if (r_hit) begin
                valid_q[r_idx] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
// Purpose : Self-checking bench for branch_predictor. Directed scenarios
//           followed by randomized resolves, all compared against a
//           behavioural BTB model kept here.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] f_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        r_valid;
    logic [31:0] r_pc;
    logic [1:0]  r_branchop;
    logic        r_taken;
    logic [31:0] r_target;
    logic        r_pred_taken;
    logic [31:0] r_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [15:0] branch_cnt;
    logic [15:0] miss_cnt;

    int test_cnt = 0;
    int fail_cnt = 0;

    // Behavioural model: 16 entries selected by word address mod 16,
    // tag is the PC divided by 64
    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    int          m_cnt   [16];
    logic [31:0] m_tgt   [16];
    bit          m_misp;
    logic [31:0] m_redir;
    logic [15:0] m_bcnt;
    logic [15:0] m_mcnt;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk           (clk),
        .rst           (rst),
        .f_pc          (f_pc),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .r_valid       (r_valid),
        .r_pc          (r_pc),
        .r_branchop    (r_branchop),
        .r_taken       (r_taken),
        .r_target      (r_target),
        .r_pred_taken  (r_pred_taken),
        .r_pred_target (r_pred_target),
        .mispredict    (mispredict),
        .redirect_pc   (redirect_pc),
        .branch_cnt    (branch_cnt),
        .miss_cnt      (miss_cnt)
    );

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc / 64;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_cnt[i]   = 1;
            m_tgt[i]   = '0;
        end
        m_misp  = 1'b0;
        m_redir = '0;
        m_bcnt  = '0;
        m_mcnt  = '0;
    endtask

    task automatic model_predict(input logic [31:0] pc, output logic tk, output logic [31:0] tgt);
        int  i;
        bit  h;
        i   = idx_of(pc);
        h   = m_valid[i] && (m_tag[i] == tag_of(pc));
        tk  = h && (m_cnt[i] >= 2);
        tgt = h ? m_tgt[i] : pc + 32'd4;
    endtask

    // Apply one clock edge of behaviour to the model using the driven inputs
    task automatic model_edge();
        bit ev;
        bit m;
        bit h;
        int i;
        ev = r_valid && !m_misp;
        if (r_branchop != 2'd0)
            m = (r_taken != r_pred_taken) || (r_taken && (r_target != r_pred_target));
        else
            m = r_pred_taken;
        i = idx_of(r_pc);
        h = m_valid[i] && (m_tag[i] == tag_of(r_pc));
        if (ev && m) begin
            m_redir = r_taken ? r_target : r_pc + 32'd4;
            m_mcnt  = m_mcnt + 16'd1;
        end
        if (ev && r_branchop != 2'd0) begin
            m_bcnt = m_bcnt + 16'd1;
            if (h) begin
                if (r_taken) begin
                    m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
                    m_tgt[i] = r_target;
                end else begin
                    m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
                end
            end else if (r_taken) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = tag_of(r_pc);
                m_tgt[i]   = r_target;
                m_cnt[i]   = (r_branchop == 2'd3) ? 3 : 2;
            end
        end else if (ev && h) begin
            m_valid[i] = 1'b0;
        end
        m_misp = ev && m;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        test_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] fpc, input logic v, input logic [31:0] pc,
                                 input logic [1:0] op, input logic tk, input logic [31:0] tgt,
                                 input logic ptk, input logic [31:0] ptgt);
        f_pc          = fpc;
        r_valid       = v;
        r_pc          = pc;
        r_branchop    = op;
        r_taken       = tk;
        r_target      = tgt;
        r_pred_taken  = ptk;
        r_pred_target = ptgt;
    endtask

    // Drive a resolve carrying the prediction the model would have made for its PC
    task automatic applyCarried(input logic [31:0] fpc, input logic [31:0] pc,
                                input logic [1:0] op, input logic tk, input logic [31:0] tgt);
        logic        ptk;
        logic [31:0] ptgt;
        model_predict(pc, ptk, ptgt);
        applyStimulus(fpc, 1'b1, pc, op, tk, tgt, ptk, ptgt);
    endtask

    // Entered just after a falling edge with inputs already driven
    task automatic do_cycle();
        logic        etk;
        logic [31:0] etgt;
        #1;
        model_predict(f_pc, etk, etgt);
        checkOutput("pred_taken", {31'd0, pred_taken}, {31'd0, etk});
        checkOutput("pred_target", pred_target, etgt);
        @(posedge clk);
        model_edge();
        #1;
        checkOutput("mispredict", {31'd0, mispredict}, {31'd0, m_misp});
        checkOutput("redirect_pc", redirect_pc, m_redir);
        checkOutput("branch_cnt", {16'd0, branch_cnt}, {16'd0, m_bcnt});
        checkOutput("miss_cnt", {16'd0, miss_cnt}, {16'd0, m_mcnt});
        @(negedge clk);
    endtask

    task automatic idle(input logic [31:0] fpc);
        applyStimulus(fpc, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    initial begin
        logic [31:0] rpc;
        logic [31:0] rtgt;
        logic [1:0]  op;
        logic        tk;

        rst = 1'b1;
        idle(32'h0040_0010);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Cold lookup after reset
        #1;
        checkOutput("reset_pred_taken", {31'd0, pred_taken}, 32'd0);
        checkOutput("reset_pred_target", pred_target, 32'h0040_0014);
        checkOutput("reset_branch_cnt", {16'd0, branch_cnt}, 32'd0);
        checkOutput("reset_miss_cnt", {16'd0, miss_cnt}, 32'd0);
        @(negedge clk);

        // Cold taken beq mispredicts and allocates
        applyStimulus(32'h0040_0020, 1'b1, 32'h0040_0020, 2'd1, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0024);
        do_cycle();
        checkOutput("cold_redirect", redirect_pc, 32'h0040_0040);
        checkOutput("cold_miss_cnt", {16'd0, miss_cnt}, 32'd1);

        // Wrong-path beq during the pulse is ignored; lookup now hits
        applyStimulus(32'h0040_0020, 1'b1, 32'h0040_0020, 2'd1, 1'b0, 32'h0, 1'b1, 32'h0040_0040);
        do_cycle();
        checkOutput("squash_branch_cnt", {16'd0, branch_cnt}, 32'd1);
        checkOutput("squash_mispredict", {31'd0, mispredict}, 32'd0);

        // Same beq not taken twice
        applyCarried(32'h0040_0020, 32'h0040_0020, 2'd1, 1'b0, 32'h0);
        do_cycle();
        checkOutput("nt1_redirect", redirect_pc, 32'h0040_0024);
        idle(32'h0040_0020);
        do_cycle();
        applyCarried(32'h0040_0020, 32'h0040_0020, 2'd1, 1'b0, 32'h0);
        do_cycle();
        checkOutput("nt2_mispredict", {31'd0, mispredict}, 32'd0);
        idle(32'h0040_0020);
        do_cycle();

        // Cold jump allocates strongly taken
        applyCarried(32'h0040_0100, 32'h0040_0100, 2'd3, 1'b1, 32'h0040_0200);
        do_cycle();
        idle(32'h0040_0100);
        do_cycle();
        checkOutput("jump_pred_taken", {31'd0, pred_taken}, 32'd1);

        // Re-train 0x00400020 taken, then alias tests with a non-branch
        applyCarried(32'h0040_0060, 32'h0040_0020, 2'd1, 1'b1, 32'h0040_0040);
        do_cycle();
        idle(32'h0040_0020);
        do_cycle();
        applyStimulus(32'h0040_0020, 1'b1, 32'h0040_0060, 2'd0, 1'b0, 32'h0, 1'b1, 32'h0040_0040);
        do_cycle();
        checkOutput("alias_redirect", redirect_pc, 32'h0040_0064);
        applyStimulus(32'h0040_0020, 1'b1, 32'h0040_0020, 2'd0, 1'b0, 32'h0, 1'b1, 32'h0040_0040);
        do_cycle();
        idle(32'h0040_0020);
        do_cycle();
        applyStimulus(32'h0040_0020, 1'b1, 32'h0040_0020, 2'd0, 1'b0, 32'h0, 1'b1, 32'h0040_0040);
        @(posedge clk);
        model_edge();
        #1;
        checkOutput("stale_mispredict", {31'd0, mispredict}, {31'd0, m_misp});

        // Async reset in the middle of the pulse
        rst = 1'b1;
        #1;
        model_reset();
        checkOutput("rst_mid_mispredict", {31'd0, mispredict}, 32'd0);
        checkOutput("rst_mid_miss_cnt", {16'd0, miss_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(32'h0040_0020);
        do_cycle();

        // Randomized resolves over a small PC pool with two aliasing bases
        for (int n = 0; n < 400; n++) begin
            rpc  = ($urandom_range(0, 1) ? 32'h0040_0000 : 32'h0041_0000) + 32'($urandom_range(0, 23)) * 4;
            rtgt = 32'h0040_0000 + 32'($urandom_range(0, 63)) * 4;
            op   = 2'($urandom_range(0, 3));
            tk   = (op == 2'd3) ? 1'b1 : (op == 2'd0) ? 1'b0 : 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                applyStimulus(rpc ^ 32'h0001_0000, 1'($urandom_range(0, 1)), rpc, op, tk, rtgt,
                              1'($urandom_range(0, 1)), rtgt);
            end else begin
                applyCarried(rpc ^ 32'h0001_0000, rpc, op, tk, rtgt);
                r_valid = 1'($urandom_range(0, 4) != 0);
            end
            do_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
